// File: rtl/psum_accum_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// psum_accum_ctrl_pkg
// Shared definitions for the psum drain/accumulate controller:
//   - state_t : controller state encoding (IDLE, POP, ACC, WR, DONE)
//   - SRAM control encodings (chip enable and write enable are active-low)
// -----------------------------------------------------------------------------
package psum_accum_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POP  = 3'd1,
        ST_ACC  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic MEM_CEN_ON    = 1'b0;
    localparam logic MEM_CEN_OFF   = 1'b1;
    localparam logic MEM_WEN_WRITE = 1'b0;
    localparam logic MEM_WEN_READ  = 1'b1;

endpackage

// File: rtl/psum_accum_ctrl_lane_add.sv
// -----------------------------------------------------------------------------
// psum_lane_add
// One psum lane of the accumulator: wrap-around two's complement add of the
// popped OFIFO value and the previous SRAM value, with the SRAM operand forced
// to zero on the first kernel pass and optional ReLU clamping.
// Ports:
//   i_a      : psum from the OFIFO word
//   i_b      : psum read back from the SRAM
//   i_zero_b : ignore i_b (first pass, SRAM contents are stale)
//   i_relu   : clamp negative results to zero
//   o_sum    : lane result
// -----------------------------------------------------------------------------
module psum_lane_add
    import psum_accum_ctrl_pkg::*;
#(
    parameter int psum_bw = 16
) (
    input  logic [psum_bw-1:0] i_a,
    input  logic [psum_bw-1:0] i_b,
    input  logic               i_zero_b,
    input  logic               i_relu,
    output logic [psum_bw-1:0] o_sum
);

    logic [psum_bw-1:0] w_b;
    logic [psum_bw-1:0] w_sum;

    // Operand select, wrap-around add and ReLU clamp.
    always_comb begin
        if (i_zero_b) begin
            w_b = '0;
        end else begin
            w_b = i_b;
        end
        w_sum = i_a + w_b;
        if (i_relu && w_sum[psum_bw-1]) begin
            o_sum = '0;
        end else begin
            o_sum = w_sum;
        end
    end

endmodule

// File: rtl/psum_accum_ctrl.sv
// -----------------------------------------------------------------------------
// psum_accum_ctrl
// Drain stage behind the corelet OFIFO. Pops one col-wide psum word per output
// pixel and accumulates it into a single-port psum SRAM over num_kij kernel
// passes, with optional ReLU on the last pass. Each element takes three
// cycles: POP (pop + SRAM read), ACC (add), WR (SRAM write).
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start               : launch pulse, only honoured in IDLE
//   len_onij, num_kij   : pixels per pass / number of passes (0 acts as 1)
//   relu_en             : ReLU on the final pass
//   ofifo_valid/output  : OFIFO head; ofifo_rd pops it on the same edge
//   mem_cen/wen/a/d/q   : single-port SRAM (active-low cen/wen, q 1 cycle late)
//   busy, done, kij_cnt : status
// -----------------------------------------------------------------------------
module psum_accum_ctrl
    import psum_accum_ctrl_pkg::*;
#(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_w  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [addr_w:0]        len_onij,
    input  logic [3:0]             num_kij,
    input  logic                   relu_en,
    input  logic                   ofifo_valid,
    input  logic [col*psum_bw-1:0] ofifo_output,
    output logic                   ofifo_rd,
    output logic                   mem_cen,
    output logic                   mem_wen,
    output logic [addr_w-1:0]      mem_a,
    output logic [col*psum_bw-1:0] mem_d,
    input  logic [col*psum_bw-1:0] mem_q,
    output logic                   busy,
    output logic                   done,
    output logic [3:0]             kij_cnt
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [addr_w-1:0]      r_onij;
    logic [3:0]             r_kij;
    logic [addr_w:0]        r_last_onij;
    logic [3:0]             r_last_kij;
    logic                   r_relu;
    logic [col*psum_bw-1:0] r_data_q;
    logic [col*psum_bw-1:0] r_sum_q;

    logic [addr_w:0]        w_len_m1;
    logic [3:0]             w_num_m1;
    logic                   w_onij_last;
    logic                   w_kij_last;
    logic                   w_first_pass;
    logic                   w_relu_now;
    logic [col*psum_bw-1:0] w_sum;

    // A zero length or pass count behaves like one, so the stored limit saturates at 0.
    assign w_len_m1     = (len_onij == '0) ? '0 : (len_onij - {{addr_w{1'b0}}, 1'b1});
    assign w_num_m1     = (num_kij == 4'd0) ? 4'd0 : (num_kij - 4'd1);
    assign w_onij_last  = ({1'b0, r_onij} == r_last_onij);
    assign w_kij_last   = (r_kij == r_last_kij);
    assign w_first_pass = (r_kij == 4'd0);
    assign w_relu_now   = r_relu && w_kij_last;

    for (genvar g = 0; g < col; g++) begin : g_lane
        psum_lane_add #(
            .psum_bw (psum_bw)
        ) u_lane (
            .i_a      (r_data_q[g*psum_bw +: psum_bw]),
            .i_b      (mem_q[g*psum_bw +: psum_bw]),
            .i_zero_b (w_first_pass),
            .i_relu   (w_relu_now),
            .o_sum    (w_sum[g*psum_bw +: psum_bw])
        );
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters, latched configuration and the data pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_onij      <= '0;
            r_kij       <= 4'd0;
            r_last_onij <= '0;
            r_last_kij  <= 4'd0;
            r_relu      <= 1'b0;
            r_data_q    <= '0;
            r_sum_q     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_onij      <= '0;
                        r_kij       <= 4'd0;
                        r_last_onij <= w_len_m1;
                        r_last_kij  <= w_num_m1;
                        r_relu      <= relu_en;
                    end
                end
                ST_POP: begin
                    if (ofifo_valid) begin
                        r_data_q <= ofifo_output;
                    end
                end
                ST_ACC: begin
                    r_sum_q <= w_sum;
                end
                ST_WR: begin
                    if (!w_onij_last) begin
                        r_onij <= r_onij + {{(addr_w-1){1'b0}}, 1'b1};
                    end else if (!w_kij_last) begin
                        r_onij <= '0;
                        r_kij  <= r_kij + 4'd1;
                    end else begin
                        r_onij <= r_onij;
                    end
                end
                default: begin
                    r_onij <= r_onij;
                end
            endcase
        end
    end

    // Next-state and SRAM/OFIFO strobes decoded from the registered state.
    always_comb begin
        w_state_nxt = r_state;
        ofifo_rd    = 1'b0;
        mem_cen     = MEM_CEN_OFF;
        mem_wen     = MEM_WEN_READ;
        mem_a       = '0;
        mem_d       = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_POP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_POP: begin
                // Pop and fetch the previous partial sum in the same cycle.
                if (ofifo_valid) begin
                    ofifo_rd    = 1'b1;
                    mem_cen     = MEM_CEN_ON;
                    mem_wen     = MEM_WEN_READ;
                    mem_a       = r_onij;
                    w_state_nxt = ST_ACC;
                end else begin
                    w_state_nxt = ST_POP;
                end
            end
            ST_ACC: begin
                w_state_nxt = ST_WR;
            end
            ST_WR: begin
                mem_cen = MEM_CEN_ON;
                mem_wen = MEM_WEN_WRITE;
                mem_a   = r_onij;
                mem_d   = r_sum_q;
                if (w_onij_last && w_kij_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_POP;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_DONE);
    assign kij_cnt = r_kij;

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// -----------------------------------------------------------------------------
// tb_psum_accum_ctrl
// Self-checking bench for psum_accum_ctrl with an OFIFO model, an SRAM model and
// a behavioural accumulation model (expected write stream + final SRAM image).
// -----------------------------------------------------------------------------
module tb_psum_accum_ctrl;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int AW    = 4;
    localparam int W     = COL * BW;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   len_onij = '0;
    logic [3:0]    num_kij = 4'd0;
    logic          relu_en = 1'b0;
    logic          ofifo_valid = 1'b0;
    logic [W-1:0]  ofifo_output = '0;
    logic          ofifo_rd;
    logic          mem_cen;
    logic          mem_wen;
    logic [AW-1:0] mem_a;
    logic [W-1:0]  mem_d;
    logic [W-1:0]  mem_q = '0;
    logic          busy;
    logic          done;
    logic [3:0]    kij_cnt;

    psum_accum_ctrl #(.col(COL), .psum_bw(BW), .addr_w(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .len_onij(len_onij),
        .num_kij(num_kij), .relu_en(relu_en), .ofifo_valid(ofifo_valid),
        .ofifo_output(ofifo_output), .ofifo_rd(ofifo_rd), .mem_cen(mem_cen),
        .mem_wen(mem_wen), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q),
        .busy(busy), .done(done), .kij_cnt(kij_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           addr;
        int           kij;
        logic [W-1:0] data;
    } wr_t;

    logic [W-1:0] sram [DEPTH];
    logic [W-1:0] fifo_q [$];
    logic [W-1:0] words_q [$];
    wr_t          exp_wr [$];
    int           errors = 0;
    int           checks = 0;
    int           pops = 0;
    bit           gate_rand = 1'b0;
    bit           mon_en = 1'b0;
    bit           s_rd = 1'b0;
    bit           s_cen = 1'b1;
    bit           s_wen = 1'b1;
    logic [AW-1:0] s_a = '0;
    logic [W-1:0]  s_d = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int i = 0; i < COL; i++) w[i*BW +: BW] = 16'($urandom);
        return w;
    endfunction

    // Monitor: samples DUT outputs mid-cycle and checks pops and writes against the model.
    initial forever begin
        @(negedge clk);
        s_rd = ofifo_rd; s_cen = mem_cen; s_wen = mem_wen; s_a = mem_a; s_d = mem_d;
        if (mon_en) begin
            if (ofifo_rd) begin
                chk("pop_valid", ofifo_valid, 1'b1);
                if (exp_wr.size() == 0) begin
                    chk("pop_extra", 1'b1, 1'b0);
                end else begin
                    chk("rd_cen", mem_cen, 1'b0);
                    chk("rd_wen", mem_wen, 1'b1);
                    chk("rd_addr", mem_a, exp_wr[0].addr);
                end
            end
            if (!mem_cen && !mem_wen) begin
                if (exp_wr.size() == 0) begin
                    chk("wr_extra", 1'b1, 1'b0);
                end else begin
                    chk("wr_addr", mem_a, exp_wr[0].addr);
                    chk("wr_data", mem_d, exp_wr[0].data);
                    chk("wr_kij", kij_cnt, exp_wr[0].kij);
                    void'(exp_wr.pop_front());
                end
            end
        end
    end

    // Environment: OFIFO pop and SRAM access on the clock edge, then present new inputs.
    initial forever begin
        @(posedge clk);
        #1;
        if (s_rd && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pops++;
        end
        if (!s_cen) begin
            if (s_wen) mem_q = sram[s_a];
            else sram[s_a] = s_d;
        end
        ofifo_valid = (fifo_q.size() != 0) && (gate_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
        ofifo_output = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    end

    // One full run: words_q holds the pass-major OFIFO stream prepared by the caller.
    task automatic run(input int len_in, input int nk_in, input bit relu, input bit bp, input bit poke);
        int leff, keff, n, cyc;
        int acc [DEPTH][COL];
        logic [W-1:0] w;
        logic [BW-1:0] lv;
        wr_t e;
        leff = (len_in == 0) ? 1 : len_in;
        keff = (nk_in == 0) ? 1 : nk_in;
        n = leff * keff;
        for (int k = 0; k < keff; k++) begin
            for (int o = 0; o < leff; o++) begin
                w = words_q[k*leff + o];
                for (int i = 0; i < COL; i++) begin
                    if (k == 0) acc[o][i] = int'($signed(w[i*BW +: BW]));
                    else acc[o][i] = acc[o][i] + int'($signed(w[i*BW +: BW]));
                    lv = acc[o][i][BW-1:0];
                    if (relu && k == keff - 1 && lv[BW-1]) lv = '0;
                    e.data[i*BW +: BW] = lv;
                end
                e.addr = o;
                e.kij = k;
                exp_wr.push_back(e);
            end
        end
        fifo_q = words_q;
        pops = 0;
        gate_rand = bp;
        mon_en = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b1; len_onij = (AW+1)'(len_in); num_kij = 4'(nk_in); relu_en = relu;
        cyc = 0;
        while (cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("busy_idle", busy, 1'b0);
            else chk("busy_run", busy, 1'b1);
            if (cyc == 2) start = 1'b0;
            if (poke && cyc == 5) begin start = 1'b1; len_onij = 5'd1; num_kij = 4'd1; end
            if (poke && cyc == 6) start = 1'b0;
            if (done) break;
        end
        chk("done_seen", done, 1'b1);
        if (!bp) chk("latency", cyc, 3*n + 2);
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after", busy, 1'b0);
        chk("done_pulse", done, 1'b0);
        chk("wr_left", exp_wr.size(), 0);
        chk("pop_count", pops, n);
        chk("fifo_left", fifo_q.size(), 0);
        for (int o = 0; o < leff; o++) begin
            for (int i = 0; i < COL; i++) begin
                int s;
                s = 0;
                for (int k = 0; k < keff; k++) s += int'($signed(words_q[k*leff + o][i*BW +: BW]));
                lv = s[BW-1:0];
                if (relu && lv[BW-1]) lv = '0;
                w[i*BW +: BW] = lv;
            end
            chk("sram_final", sram[o], w);
        end
        exp_wr.delete();
        mon_en = 1'b0;
        gate_rand = 1'b0;
    endtask

    initial begin
        logic [W-1:0] w;
        int cyc;
        for (int a = 0; a < DEPTH; a++) sram[a] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd", ofifo_rd, 1'b0);
        chk("rst_cen", mem_cen, 1'b1);
        chk("rst_wen", mem_wen, 1'b1);
        chk("rst_a", mem_a, '0);
        chk("rst_d", mem_d, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_kij", kij_cnt, '0);
        #1 reset = 1'b0;

        // Reset mid-WR with ofifo_valid high.
        words_q.delete();
        for (int i = 0; i < 4; i++) words_q.push_back(rand_word());
        fifo_q = words_q;
        @(posedge clk); #2;
        start = 1'b1; len_onij = 5'd4; num_kij = 4'd1; relu_en = 1'b0;
        @(posedge clk); #2 start = 1'b0;
        cyc = 0;
        while (cyc < 50 && !(mem_cen == 1'b0 && mem_wen == 1'b0)) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_wr", cyc < 50, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("mrst_cen", mem_cen, 1'b1);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_rd", ofifo_rd, 1'b0);
        chk("mrst_valid", ofifo_valid, 1'b1);
        s_cen = 1'b1; s_rd = 1'b0;
        fifo_q.delete();
        @(negedge clk);
        reset = 1'b0;

        // Single pass, lane0 = 5,-3,7,0.
        words_q.delete();
        for (int i = 0; i < 4; i++) begin
            w = rand_word();
            case (i)
                0: w[15:0] = 16'd5;
                1: w[15:0] = 16'hFFFD;
                2: w[15:0] = 16'd7;
                default: w[15:0] = 16'd0;
            endcase
            words_q.push_back(w);
        end
        run(4, 1, 1'b0, 1'b0, 1'b0);
        chk("sp_l0_0", sram[0][15:0], 16'd5);
        chk("sp_l0_1", sram[1][15:0], 16'hFFFD);
        chk("sp_l0_2", sram[2][15:0], 16'd7);
        chk("sp_l0_3", sram[3][15:0], 16'd0);

        // Accumulate over stale SRAM contents.
        for (int a = 0; a < DEPTH; a++) sram[a] = {COL{16'h7777}};
        words_q.delete();
        for (int i = 0; i < 6; i++) words_q.push_back({COL{16'd2}});
        run(2, 3, 1'b0, 1'b0, 1'b0);
        chk("acc_0", sram[0], {COL{16'd6}});
        chk("acc_1", sram[1], {COL{16'd6}});

        // ReLU on the final pass, then the same stream without ReLU.
        words_q.delete();
        w = '0; w[15:0] = 16'hFFFC; w[31:16] = 16'd3; words_q.push_back(w);
        w = '0; w[15:0] = 16'd1;    w[31:16] = 16'd3; words_q.push_back(w);
        run(1, 2, 1'b1, 1'b0, 1'b0);
        chk("relu_l0", sram[0][15:0], 16'd0);
        chk("relu_l1", sram[0][31:16], 16'd6);
        run(1, 2, 1'b0, 1'b0, 1'b0);
        chk("norelu_l0", sram[0][15:0], 16'hFFFD);

        // Backpressure over 16 random elements.
        words_q.delete();
        for (int i = 0; i < 16; i++) words_q.push_back(rand_word());
        run(16, 1, 1'b0, 1'b1, 1'b0);

        // Multi-pass random with ReLU and backpressure.
        words_q.delete();
        for (int i = 0; i < 24; i++) words_q.push_back(rand_word());
        run(8, 3, 1'b1, 1'b1, 1'b0);

        // Wrap-around, with start pulsed while busy and in DONE.
        words_q.delete();
        words_q.push_back({COL{16'h7FFF}});
        words_q.push_back({COL{16'h0001}});
        run(1, 2, 1'b0, 1'b0, 1'b1);
        chk("wrap", sram[0], {COL{16'h8000}});

        // Zero length and zero passes behave as one.
        words_q.delete();
        words_q.push_back(rand_word());
        run(0, 0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
